// File: rtl/wrr_hold_arbiter.sv
// Weighted round-robin arbiter that holds a grant for a burst of acks.
// Define WRR_ARB_WEIGHT_EN to enable per-requester burst weights; otherwise plain round-robin.
module wrr_hold_arbiter #(
  parameter int ARBITER_WIDTH = 8,
  parameter int WEIGHT_W      = 4,
  localparam int IDX_W        = $clog2(ARBITER_WIDTH)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [ARBITER_WIDTH-1:0]            request,
  input  logic [ARBITER_WIDTH*WEIGHT_W-1:0]   weight,
  input  logic                                ack,
  output logic [ARBITER_WIDTH-1:0]            grant,
  output logic [IDX_W-1:0]                    grant_bin,
  output logic                                any_grant
);

  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] last_owner;
  logic             own_valid;
  logic             rel_now;
  logic             found;
  logic [IDX_W-1:0] pick;

`ifdef WRR_ARB_WEIGHT_EN
  logic [WEIGHT_W-1:0] credit;
  logic [WEIGHT_W-1:0] pick_weight;
  logic [WEIGHT_W-1:0] load_credit;

  always_comb begin
    rel_now = !own_valid || !request[owner] || (ack && (credit == WEIGHT_W'(1)));
  end

  // A zero weight still earns one unit so a requester can never be locked out.
  always_comb begin
    pick_weight = weight[pick*WEIGHT_W +: WEIGHT_W];
    load_credit = (pick_weight == '0) ? WEIGHT_W'(1) : pick_weight;
  end
`else
  logic unused_weight;
  assign unused_weight = ^weight;

  always_comb begin
    rel_now = !own_valid || !request[owner] || ack;
  end
`endif

  // Search starts just after the last owner, so the last owner is checked last.
  always_comb begin
    int sum;
    found = 1'b0;
    pick  = '0;
    sum   = 0;
    for (int i = 1; i <= ARBITER_WIDTH; i++) begin
      sum = int'(last_owner) + i;
      if (sum >= ARBITER_WIDTH) sum = sum - ARBITER_WIDTH;
      if (!found && request[sum]) begin
        found = 1'b1;
        pick  = IDX_W'(sum);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner      <= '0;
      last_owner <= IDX_W'(ARBITER_WIDTH-1);
      own_valid  <= 1'b0;
      grant      <= '0;
      grant_bin  <= '0;
      any_grant  <= 1'b0;
`ifdef WRR_ARB_WEIGHT_EN
      credit     <= '0;
`endif
    end else if (rel_now) begin
      if (found) begin
        owner      <= pick;
        last_owner <= pick;
        own_valid  <= 1'b1;
        grant      <= {{(ARBITER_WIDTH-1){1'b0}}, 1'b1} << pick;
        grant_bin  <= pick;
        any_grant  <= 1'b1;
`ifdef WRR_ARB_WEIGHT_EN
        credit     <= load_credit;
`endif
      end else begin
        own_valid  <= 1'b0;
        grant      <= '0;
        grant_bin  <= '0;
        any_grant  <= 1'b0;
      end
    end
`ifdef WRR_ARB_WEIGHT_EN
    else if (ack && (credit > WEIGHT_W'(1))) begin
      credit <= credit - WEIGHT_W'(1);
    end
`endif
  end

endmodule

// File: tb/tb_wrr_hold_arbiter.sv
// Directed self-checking bench for wrr_hold_arbiter at N=4; expectations follow WRR_ARB_WEIGHT_EN.
module tb_wrr_hold_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  request;
  logic [15:0] weight;
  logic        ack;
  logic [3:0]  grant;
  logic [1:0]  grant_bin;
  logic        any_grant;

  int checks = 0;
  int errors = 0;

`ifdef WRR_ARB_WEIGHT_EN
  logic [3:0] seq_grant [9] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001};
  logic [1:0] seq_bin   [9] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
`else
  logic [3:0] seq_grant [9] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [1:0] seq_bin   [9] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`endif

  wrr_hold_arbiter #(.ARBITER_WIDTH(4), .WEIGHT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .request   (request),
    .weight    (weight),
    .ack       (ack),
    .grant     (grant),
    .grant_bin (grant_bin),
    .any_grant (any_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [3:0] r, input logic a);
    request = r;
    ack     = a;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] eg, input logic [1:0] eb, input logic ea);
    checks += 3;
    assert (grant === eg) else begin
      errors++;
      $error("[TB] FAIL %s grant=%b expected %b", tag, grant, eg);
    end
    assert (grant_bin === eb) else begin
      errors++;
      $error("[TB] FAIL %s grant_bin=%0d expected %0d", tag, grant_bin, eb);
    end
    assert (any_grant === ea) else begin
      errors++;
      $error("[TB] FAIL %s any_grant=%b expected %b", tag, any_grant, ea);
    end
  endtask

  initial begin
    reset   = 1'b1;
    request = 4'b0000;
    ack     = 1'b0;
    weight  = 16'h1111;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 4'b0000, 2'd0, 1'b0);
    reset = 1'b0;

    applyStimulus(4'b0000, 1'b0);
    checkOutput("idle", 4'b0000, 2'd0, 1'b0);
    applyStimulus(4'b0100, 1'b0);
    checkOutput("idle_to_2", 4'b0100, 2'd2, 1'b1);

    // Requester 2 drops, then 1 and 3 alternate one unit each.
    applyStimulus(4'b1010, 1'b1);
    checkOutput("alt_a", 4'b1000, 2'd3, 1'b1);
    applyStimulus(4'b1010, 1'b1);
    checkOutput("alt_b", 4'b0010, 2'd1, 1'b1);
    applyStimulus(4'b1010, 1'b1);
    checkOutput("alt_c", 4'b1000, 2'd3, 1'b1);
    applyStimulus(4'b1010, 1'b1);
    checkOutput("alt_d", 4'b0010, 2'd1, 1'b1);

    weight = 16'h1101;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0010, 1'b1);
      checkOutput("zero_weight_sole", 4'b0010, 2'd1, 1'b1);
    end

    applyStimulus(4'b0010, 1'b0);
    checkOutput("hold_no_ack", 4'b0010, 2'd1, 1'b1);
    applyStimulus(4'b0001, 1'b0);
    checkOutput("drop_wrap_0", 4'b0001, 2'd0, 1'b1);

    weight = 16'h1111;
    applyStimulus(4'b1111, 1'b0);
    checkOutput("all_hold", 4'b0001, 2'd0, 1'b1);
    applyStimulus(4'b1111, 1'b1);
    checkOutput("rr_1", 4'b0010, 2'd1, 1'b1);
    applyStimulus(4'b1111, 1'b1);
    checkOutput("rr_2", 4'b0100, 2'd2, 1'b1);
    applyStimulus(4'b1111, 1'b1);
    checkOutput("rr_3", 4'b1000, 2'd3, 1'b1);
    applyStimulus(4'b1111, 1'b1);
    checkOutput("rr_0", 4'b0001, 2'd0, 1'b1);

    // Asynchronous reset while requester 3 owns the bus.
    applyStimulus(4'b1000, 1'b0);
    checkOutput("pre_reset_3", 4'b1000, 2'd3, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset", 4'b0000, 2'd0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset_held", 4'b0000, 2'd0, 1'b0);
    applyStimulus(4'b1111, 1'b0);
    checkOutput("post_reset_first", 4'b0001, 2'd0, 1'b1);

    weight = 16'h0302;
    applyStimulus(4'b0100, 1'b0);
    checkOutput("own_2", 4'b0100, 2'd2, 1'b1);
    applyStimulus(4'b0011, 1'b0);
    checkOutput("drop_2_to_0", 4'b0001, 2'd0, 1'b1);
`ifdef WRR_ARB_WEIGHT_EN
    applyStimulus(4'b0011, 1'b1);
    checkOutput("credit0_hold", 4'b0001, 2'd0, 1'b1);
    applyStimulus(4'b0011, 1'b1);
    checkOutput("credit0_done", 4'b0010, 2'd1, 1'b1);
`else
    applyStimulus(4'b0011, 1'b1);
    checkOutput("plain_ack_1", 4'b0010, 2'd1, 1'b1);
    applyStimulus(4'b0011, 1'b1);
    checkOutput("plain_ack_0", 4'b0001, 2'd0, 1'b1);
`endif

    reset = 1'b1;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    weight = 16'h2222;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(4'b1111, 1'b1);
      checkOutput($sformatf("burst_%0d", i), seq_grant[i], seq_bin[i], 1'b1);
    end

    applyStimulus(4'b0000, 1'b0);
    checkOutput("final_idle", 4'b0000, 2'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wrr_hold_arbiter.md
WRR_HOLD_ARBITER -- requirements
Module: wrr_hold_arbiter

Interface
REQ-001 Parameter ARBITER_WIDTH, default 8, number of requesters N; legal range 2..64.
REQ-002 Parameter WEIGHT_W, default 4, width of each per-requester weight field.
REQ-003 Port clk  input  1  clock; all state updates on the rising edge.
REQ-004 Port reset  input  1  reset, asynchronous, active-high.
REQ-005 Port request  input  N  per-requester request; a requester holds it high until it has been served.
REQ-006 Port weight  input  N*WEIGHT_W  per-requester burst weight; field i is bits [(i+1)*WEIGHT_W-1 : i*WEIGHT_W].
REQ-007 Port ack  input  1  consumer accepted one unit from the current grantee this cycle.
REQ-008 Port grant  output  N  registered one-hot grant; all zero when no owner.
REQ-009 Port grant_bin  output  ceil(log2 N)  registered binary index of the owner; 0 when no owner.
REQ-010 Port any_grant  output  1  registered; high exactly when grant is non-zero.

Function
REQ-011 Internal state: owner index, own_valid flag, credit counter (WEIGHT_W bits), last_owner index.
REQ-012 A release occurs on any of the following:
- own_valid=0;
- request[owner]=0 while own_valid=1;
- ack=1 while credit=1.
REQ-013 On a release, the arbiter searches request round-robin, starting at (last_owner+1) mod N and wrapping. The former owner is the lowest priority, but it is still eligible if it is the only requester.
REQ-014 If the search finds requester k:
- next edge: owner<=k, last_owner<=k, own_valid<=1;
- credit<=weight[k], with a weight of 0 loaded as 1.
REQ-015 If the search finds no requester, next edge: own_valid<=0. Credit and last_owner are unchanged.
REQ-016 If ack=1, own_valid=1, request[owner]=1 and credit>1, then credit<=credit-1. Owner is unchanged.
REQ-017 ack is ignored while own_valid=0.
REQ-018 Latency: a request arriving while the arbiter is idle sees grant on the first rising edge after it is sampled (1 cycle).
REQ-019 Back-to-back handover: when a release and a new winner occur in the same cycle, grant switches directly from the old one-hot to the new one-hot with no idle cycle.
REQ-020 Simultaneous ack with credit=1 and request[owner] drop: this counts as a single release. Exactly one arbitration happens.
REQ-021 The weight input is sampled only when credit is loaded. Changing weight during ownership has no effect until the next grant.
REQ-022 grant, grant_bin and any_grant are driven directly from registers, with no combinational path from inputs.
REQ-023 grant is never multi-hot.
REQ-024 Starvation bound: a continuously asserted request is granted within (N-1)*max(weight,1) acks plus N-1 release cycles.

Reset
REQ-025 While reset=1:
- own_valid=0, owner=0, credit=0;
- last_owner=N-1, so that requester 0 has first priority after reset;
- grant=0, grant_bin=0, any_grant=0.
REQ-026 Reset asserted mid-burst takes effect immediately, asynchronously, and discards the remaining credit. After deassertion, arbitration restarts from requester 0.

Configuration
REQ-027 Macro WRR_ARB_WEIGHT_EN, when defined, enables the weighted burst behaviour of REQ-014 and REQ-016.
REQ-028 With WRR_ARB_WEIGHT_EN undefined:
- credit is fixed at 1 and the credit counter is not synthesised;
- every accepted ack releases ownership (plain round-robin, one unit per grant);
- the weight port remains present and is ignored.

Verification
REQ-029 N=4, macro defined, weights all 2, request=4'b1111, ack=1 every cycle -> grant sequence 0001,0001,0010,0010,0100,0100,1000,1000,0001...
REQ-030 N=4, macro undefined, request=4'b1010, ack=1 every cycle -> grant alternates 0010,1000,0010,1000, with no idle cycle between grants.
REQ-031 N=4, owner=2 with credit=3, then request[2] drops with ack=0 while request=4'b0011 -> next edge grant=0001, credit loaded from weight[0].
REQ-032 N=4, weight[1]=0, only request[1] high, ack=1 each cycle -> grant stays 0010 and credit reloads to 1 every cycle; any_grant stays 1.
REQ-033 Reset pulse mid-burst (owner=3, credit=2), request=4'b1111 afterwards -> grant=0 during reset; first grant after reset is 0001.
REQ-034 Idle check: request=0 -> grant=0, any_grant=0, grant_bin=0. Then request=4'b0100 -> grant=0100 and grant_bin=2 one edge later.
